mod_seq_unit: RTL and testbench

Multi-cycle unsigned modulus/divide unit that supplies the result for the ALU's MOD slot (alu_ctr = 3'b111, mux input 7), which has no combinational result.
- Restoring shift-subtract algorithm, one quotient bit per clock.
- Start/busy/done handshake; the controller stalls on busy.
- Result is held stable for the ALU result mux until the next accepted start.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/mod_step.sv | 18 +
 rtl/mod_seq_unit.sv | 81 ++++++++
 tb/tb_mod_seq_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM encoding, ALU control codes and default datapath width
package cpu_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    localparam logic [2:0] ALU_CTR_MOD   = 3'b111;
    localparam int         DEFAULT_WIDTH = 32;
endpackage

// File: rtl/mod_step.sv
// mod_step: one restoring shift-subtract iteration producing next remainder and quotient bit
module mod_step #(
    parameter int WIDTH = cpu_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    // the extra bit keeps the shifted remainder exact when the divisor MSB is set
    assign shifted = {r, q_msb};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign r_next  = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/mod_seq_unit.sv
// mod_seq_unit: multi-cycle unsigned divide/modulus unit feeding the ALU MOD result slot
module mod_seq_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] quotient
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dv;
    logic [WIDTH-1:0] r_next;
    logic             q_bit;

    mod_step #(.WIDTH(WIDTH)) u_step (
        .r       (r),
        .q_msb   (q[WIDTH-1]),
        .divisor (dv),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            r           <= '0;
            q           <= '0;
            dv          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            remainder   <= '0;
            quotient    <= '0;
        end else if (state == ST_RUN) begin
            r   <= r_next;
            q   <= {q[WIDTH-2:0], q_bit};
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
                state     <= ST_DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                remainder <= r_next;
                quotient  <= {q[WIDTH-2:0], q_bit};
            end
        end else begin
            done <= 1'b0;
            if (start) begin
                q           <= dividend;
                dv          <= divisor;
                r           <= '0;
                cnt         <= '0;
                div_by_zero <= (divisor == '0);
                // a zero divisor skips iteration entirely and reports immediately
                if (divisor == '0) begin
                    state     <= ST_DONE;
                    done      <= 1'b1;
                    remainder <= dividend;
                    quotient  <= '1;
                end else begin
                    state <= ST_RUN;
                    busy  <= 1'b1;
                end
            end else begin
                state <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mod_seq_unit.sv
// tb_mod_seq_unit: directed and random checks of mod_seq_unit against an arithmetic model
module tb_mod_seq_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] remainder;
    logic [31:0] quotient;
    int          checks = 0;
    int          failures = 0;

    mod_seq_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .remainder   (remainder),
        .quotient    (quotient)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // counts negedges until done, starting at cycle index n0; also tallies busy cycles
    task automatic wait_done(input int n0, output int n, output int bc);
        n  = n0;
        bc = 0;
        while (!done && n < 100) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
        int n;
        int bc;
        logic [31:0] er;
        logic [31:0] eq;
        er = (b == 0) ? a : a % b;
        eq = (b == 0) ? 32'hFFFF_FFFF : a / b;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, n, bc);
        chk({tag, "_latency"}, n, (b == 0) ? 1 : 33);
        chk({tag, "_busy_cycles"}, bc, (b == 0) ? 0 : 32);
        chk({tag, "_busy_with_done"}, {31'b0, busy}, 32'd0);
        chk({tag, "_rem"}, remainder, er);
        chk({tag, "_quo"}, quotient, eq);
        chk({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, b == 0});
        @(negedge clk);
        chk({tag, "_done_width"}, {31'b0, done}, 32'd0);
        chk({tag, "_rem_hold"}, remainder, er);
    endtask

    initial begin
        int n;
        int bc;
        int seen;
        logic [31:0] a;
        logic [31:0] b;
        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        chk("rst_rem", remainder, 32'd0);
        chk("rst_quo", quotient, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(32'd100, 32'd7, "t1");
        run_op(32'd5, 32'd0, "t2");
        run_op(32'hFFFF_FFFF, 32'h8000_0000, "t3a");
        run_op(32'd3, 32'd10, "t3b");

        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; dividend = 32'd9; divisor = 32'd4;
        @(negedge clk);
        start = 1'b0; dividend = 32'd77; divisor = 32'd5;
        wait_done(5, n, bc);
        chk("t4_latency", n, 33);
        chk("t4_busy_cycles", bc, 28);
        chk("t4_rem", remainder, 32'd2);
        chk("t4_quo", quotient, 32'd14);
        start = 1'b1; dividend = 32'd9; divisor = 32'd4;
        @(negedge clk);
        start = 1'b0;
        chk("t4_b2b_busy", {31'b0, busy}, 32'd1);
        wait_done(1, n, bc);
        chk("t4_b2b_latency", n, 33);
        chk("t4_b2b_rem", remainder, 32'd1);
        chk("t4_b2b_quo", quotient, 32'd2);

        @(negedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("t5_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_done", {31'b0, done}, 32'd0);
        chk("t5_rem", remainder, 32'd0);
        chk("t5_quo", quotient, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("t5_no_done", seen, 0);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case (i % 8)
                0: b = 32'd1;
                1: b = a;
                2: begin a = 32'd0; b = $urandom; end
                3: b = $urandom_range(1, 255);
                4: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            run_op(a, b, "t6");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
